// File: rtl/axi4lite_tohost_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_tohost_writer_pkg
// Description : Shared AXI4-Lite response codes, bus widths and tohost
//               character-device constants, plus the tohost word builder.
// Revision    : 1.0 - initial release
// ============================================================================
package axi4lite_tohost_writer_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    localparam logic [1:0] AXI4LITE_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI4LITE_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI4LITE_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI4LITE_RESP_DECERR = 2'b11;

    // Shared with the tohost slave so both sides agree on the word layout.
    localparam logic [7:0] TOHOST_DEVICE_CHAR    = 8'h01;
    localparam logic [7:0] TOHOST_CMD_WRITE_CHAR = 8'h01;
    localparam int         TOHOST_DEVICE_POS     = 56;
    localparam int         TOHOST_COMMAND_POS    = 48;

    // Builds the 64-bit tohost word that prints one character.
    function automatic logic [AXI_DATA_W-1:0] tohost_char_word(input logic [7:0] ch);
        logic [AXI_DATA_W-1:0] w_word;
        w_word = (AXI_DATA_W'(TOHOST_DEVICE_CHAR) << TOHOST_DEVICE_POS)
               | (AXI_DATA_W'(TOHOST_CMD_WRITE_CHAR) << TOHOST_COMMAND_POS)
               | AXI_DATA_W'(ch);
        return w_word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4lite_tohost_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_tohost_writer_if
// Description : AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave
//               modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface axi4lite_tohost_writer_if;
    import axi4lite_tohost_writer_pkg::*;

    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface
`default_nettype wire

// File: rtl/axi4lite_tohost_writer_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with first-word-fall-through read data.
//               DEPTH must be a power of two, at least 2; pointers carry one
//               extra wrap bit so full and empty are distinguishable.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic [WIDTH-1:0] wdata,
    output logic      [WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int                 c_addr_w     = $clog2(DEPTH);
    localparam int                 c_ptr_w      = c_addr_w + 1;
    localparam logic [c_ptr_w-1:0] c_full_count = c_ptr_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] w_count;
    logic               w_push;
    logic               w_pop;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign full    = (w_count == c_full_count);
    assign empty   = (w_count == '0);
    assign w_push  = push && !full;
    assign w_pop   = pop && !empty;
    assign rdata   = r_mem[r_rd_ptr[c_addr_w-1:0]];

    // Pointer update; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_addr_w-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/axi4lite_tohost_writer.sv
`default_nettype none
// ============================================================================
// Module      : axi4lite_tohost_writer
// Description : AXI4-Lite initiator printing buffered characters through the
//               tohost character device, one 64-bit write per byte, with
//               response checking and a sticky error report.
// Revision    : 1.0 - initial release
// ============================================================================
module axi4lite_tohost_writer
    import axi4lite_tohost_writer_pkg::*;
#(
    parameter logic [AXI_ADDR_W-1:0] TOHOST_ADDR = '0,
    parameter int                    FIFO_DEPTH  = 8
) (
    input  wire logic                    aclk,
    input  wire logic                    areset,
    input  wire logic                    char_valid,
    output logic                         char_ready,
    input  wire logic [7:0]              char_data,
    axi4lite_tohost_writer_if.master     bus,
    output logic                         busy,
    output logic                         err,
    output logic [1:0]                   err_resp,
    output logic [31:0]                  sent_count
);

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_SEND = 2'd1;
    localparam state_t S_RESP = 2'd2;

    state_t      r_state;
    logic [7:0]  r_char;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_err;
    logic [1:0]  r_err_resp;
    logic [31:0] r_sent_count;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [7:0]  w_head;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_unused;

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign char_ready = !w_full && !areset;
    assign w_push     = char_valid && char_ready;
    assign w_pop      = (r_state == S_IDLE) && !w_empty;
    assign w_aw_hs    = r_awvalid && bus.awready;
    assign w_w_hs     = r_wvalid && bus.wready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (char_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Transaction sequencer: pop a byte, issue AW and W together, await B.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= S_IDLE;
            r_char       <= 8'h00;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_err        <= 1'b0;
            r_err_resp   <= AXI4LITE_RESP_OKAY;
            r_sent_count <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_char    <= w_head;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Each channel retires independently; the other keeps its valid.
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= S_IDLE;
                        if (bus.bresp == AXI4LITE_RESP_OKAY) begin
                            r_sent_count <= r_sent_count + 32'd1;
                        end else begin
                            // Only the first failure's code is kept.
                            if (!r_err) r_err_resp <= bus.bresp;
                            r_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_bready  <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.awaddr  = TOHOST_ADDR;
    assign bus.awvalid = r_awvalid;
    assign bus.wdata   = tohost_char_word(r_char);
    assign bus.wstrb   = {AXI_STRB_W{1'b1}};
    assign bus.wvalid  = r_wvalid;
    assign bus.bready  = r_bready;
    assign bus.araddr  = '0;
    assign bus.arvalid = 1'b0;
    assign bus.rready  = 1'b0;

    // Read channel is never used by this initiator.
    assign w_unused = ^{bus.arready, bus.rvalid, bus.rresp, bus.rdata};

    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign err        = r_err;
    assign err_resp   = r_err_resp;
    assign sent_count = r_sent_count;

endmodule
`default_nettype wire
